// File: rtl/alu_rf_sequencer_pkg.sv
// Shared definitions for the ALU/register-file sequencer: FSM state encoding and op-code constants.
package alu_rf_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_EXEC  = 2'd2,
        ST_WRITE = 2'd3
    } seq_state_t;

    // {bnegate, oper[1:0]}
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

endpackage

// File: rtl/alu_rf_sequencer.sv
// Four-cycle sequencer: read two registers, drive the ALU, capture flags, write the result back.
//   state    | meaning
//   ST_IDLE  | ready for an instruction; latch fields on handshake
//   ST_READ  | present rs/rt to register-file read ports
//   ST_EXEC  | read data on ALU operands; capture result/carry/zero at edge
//   ST_WRITE | write captured result to rd; pulse done
module alu_rf_sequencer
    import alu_rf_sequencer_pkg::*;
#(
    parameter int DATA_W     = 4,
    parameter int REG_ADDR_W = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [2:0]            instr_op,
    input  logic [REG_ADDR_W-1:0] instr_rd,
    input  logic [REG_ADDR_W-1:0] instr_rs,
    input  logic [REG_ADDR_W-1:0] instr_rt,
    output logic [REG_ADDR_W-1:0] rf_raddr_a,
    output logic [REG_ADDR_W-1:0] rf_raddr_b,
    input  logic [DATA_W-1:0]     rf_rdata_a,
    input  logic [DATA_W-1:0]     rf_rdata_b,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]     rf_wdata,
    output logic [DATA_W-1:0]     alu_a,
    output logic [DATA_W-1:0]     alu_b,
    output logic [1:0]            alu_oper,
    output logic                  alu_binvert,
    output logic                  alu_cin,
    input  logic [DATA_W-1:0]     alu_res,
    input  logic                  alu_cout,
    output logic                  done,
    output logic [DATA_W-1:0]     result,
    output logic                  carry,
    output logic                  zero
);

    seq_state_t            state, state_nxt;
    logic [2:0]            op_q;
    logic [REG_ADDR_W-1:0] rd_q, rs_q, rt_q;
    logic [DATA_W-1:0]     result_q;
    logic                  carry_q, zero_q;
    logic                  accept;

    assign accept = (state == ST_IDLE) && instr_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q <= '0;
            rd_q <= '0;
            rs_q <= '0;
            rt_q <= '0;
        end else if (accept) begin
            op_q <= instr_op;
            rd_q <= instr_rd;
            rs_q <= instr_rs;
            rt_q <= instr_rt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
        end else if (state == ST_EXEC) begin
            result_q <= alu_res;
            carry_q  <= alu_cout;
            zero_q   <= (alu_res == '0);
        end
    end

    // Outputs are decoded from state and latched fields only, so instr_* never reaches rf_*.
    always_comb begin
        state_nxt   = state;
        instr_ready = 1'b0;
        rf_raddr_a  = '0;
        rf_raddr_b  = '0;
        rf_we       = 1'b0;
        rf_waddr    = '0;
        rf_wdata    = '0;
        alu_a       = '0;
        alu_b       = '0;
        alu_oper    = 2'b00;
        alu_binvert = 1'b0;
        alu_cin     = 1'b0;
        done        = 1'b0;
        case (state)
            ST_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) state_nxt = ST_READ;
            end
            ST_READ: begin
                rf_raddr_a = rs_q;
                rf_raddr_b = rt_q;
                state_nxt  = ST_EXEC;
            end
            ST_EXEC: begin
                alu_a       = rf_rdata_a;
                alu_b       = rf_rdata_b;
                alu_oper    = op_q[1:0];
                alu_binvert = op_q[2];
                alu_cin     = op_q[2];
                state_nxt   = ST_WRITE;
            end
            ST_WRITE: begin
                rf_we     = 1'b1;
                rf_waddr  = rd_q;
                rf_wdata  = result_q;
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign result = result_q;
    assign carry  = carry_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_alu_rf_sequencer.sv
// Bench for alu_rf_sequencer: behavioural register file and 4-bit ALU around the DUT, directed table plus random instructions.
module tb_alu_rf_sequencer;
    import alu_rf_sequencer_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic [2:0] instr_op = '0, instr_rd = '0, instr_rs = '0, instr_rt = '0;
    logic [2:0] rf_raddr_a, rf_raddr_b, rf_waddr;
    logic [3:0] rf_rdata_a, rf_rdata_b, rf_wdata;
    logic       rf_we;
    logic [3:0] alu_a, alu_b, alu_res;
    logic [1:0] alu_oper;
    logic       alu_binvert, alu_cin, alu_cout;
    logic       done;
    logic [3:0] result;
    logic       carry, zero;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_rf_sequencer #(.DATA_W(4), .REG_ADDR_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs(instr_rs), .instr_rt(instr_rt),
        .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
        .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .alu_a(alu_a), .alu_b(alu_b), .alu_oper(alu_oper),
        .alu_binvert(alu_binvert), .alu_cin(alu_cin),
        .alu_res(alu_res), .alu_cout(alu_cout),
        .done(done), .result(result), .carry(carry), .zero(zero)
    );

    // Register file: one-cycle read latency, plus a bench preload port.
    logic [3:0] regs [8];
    logic       pl_we = 1'b0;
    logic [2:0] pl_addr = '0;
    logic [3:0] pl_data = '0;
    int         we_pulses = 0;

    always @(posedge clk) begin
        rf_rdata_a <= regs[rf_raddr_a];
        rf_rdata_b <= regs[rf_raddr_b];
        if (rf_we) begin
            regs[rf_waddr] <= rf_wdata;
            we_pulses      <= we_pulses + 1;
        end
        if (pl_we) regs[pl_addr] <= pl_data;
    end

    // ALU4bit stand-in: the adder runs for every operation, so cout always comes from it.
    logic [3:0] bsel;
    logic [4:0] sum;
    always_comb begin
        bsel     = alu_binvert ? ~alu_b : alu_b;
        sum      = {1'b0, alu_a} + {1'b0, bsel} + {4'b0000, alu_cin};
        alu_cout = sum[4];
        case (alu_oper)
            2'b00:   alu_res = alu_a & bsel;
            2'b01:   alu_res = alu_a | bsel;
            2'b10:   alu_res = sum[3:0];
            default: alu_res = {3'b000, sum[3]};
        endcase
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", nm, got, exp);
        end
    endtask

    task automatic preload(input logic [2:0] addr, input logic [3:0] data);
        pl_we = 1'b1; pl_addr = addr; pl_data = data;
        @(posedge clk); #1;
        pl_we = 1'b0;
    endtask

    // Reference semantics of the valid op codes, from plain arithmetic.
    function automatic void ref_op(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                                   output logic [3:0] r, output logic c, output logic z);
        int ai = int'(a);
        int bi = int'(b);
        case (op)
            OP_AND:  begin r = a & b; c = (ai + bi) > 15; end
            OP_OR:   begin r = a | b; c = (ai + bi) > 15; end
            OP_ADD:  begin r = 4'((ai + bi) % 16); c = (ai + bi) > 15; end
            OP_SUB:  begin r = 4'((ai - bi + 16) % 16); c = (ai >= bi); end
            default: begin r = (((ai - bi) & 8) != 0) ? 4'd1 : 4'd0; c = (ai >= bi); end
        endcase
        z = (r == 4'd0);
    endfunction

    task automatic exec_instr(input string nm, input logic [2:0] op,
                              input logic [2:0] rd, input logic [2:0] rs, input logic [2:0] rt,
                              input logic [3:0] ea, input logic [3:0] eb,
                              input logic [3:0] ew, input logic ec, input logic ez);
        int waits = 0;
        while (!instr_ready && waits < 8) begin
            @(posedge clk); #1;
            waits++;
        end
        chk({nm, "_idle_ready"}, instr_ready, 1);
        instr_valid = 1'b1; instr_op = op; instr_rd = rd; instr_rs = rs; instr_rt = rt;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        instr_op = 3'($urandom); instr_rd = 3'($urandom);
        instr_rs = 3'($urandom); instr_rt = 3'($urandom);
        chk({nm, "_read_ready"}, instr_ready, 0);
        chk({nm, "_raddr_a"}, rf_raddr_a, rs);
        chk({nm, "_raddr_b"}, rf_raddr_b, rt);
        chk({nm, "_read_we"}, rf_we, 0);
        @(posedge clk); #1;
        chk({nm, "_exec_ready"}, instr_ready, 0);
        chk({nm, "_alu_a"}, alu_a, ea);
        chk({nm, "_alu_b"}, alu_b, eb);
        chk({nm, "_alu_oper"}, alu_oper, op[1:0]);
        chk({nm, "_alu_binvert"}, alu_binvert, op[2]);
        chk({nm, "_alu_cin"}, alu_cin, op[2]);
        chk({nm, "_exec_done"}, done, 0);
        @(posedge clk); #1;
        chk({nm, "_write_ready"}, instr_ready, 0);
        chk({nm, "_rf_we"}, rf_we, 1);
        chk({nm, "_done"}, done, 1);
        chk({nm, "_waddr"}, rf_waddr, rd);
        chk({nm, "_wdata"}, rf_wdata, ew);
        chk({nm, "_result"}, result, ew);
        chk({nm, "_carry"}, carry, ec);
        chk({nm, "_zero"}, zero, ez);
        @(posedge clk); #1;
        chk({nm, "_after_ready"}, instr_ready, 1);
        chk({nm, "_after_we"}, rf_we, 0);
        chk({nm, "_after_done"}, done, 0);
        chk({nm, "_held_result"}, result, ew);
        chk({nm, "_rf_content"}, regs[rd], ew);
    endtask

    typedef struct {
        logic [2:0] op, rd, rs, rt;
        logic [3:0] a, b, w;
        logic       c, z;
    } vec_t;

    vec_t       vecs [11];
    logic [3:0] ref_regs [8];
    logic [2:0] ops [5];

    initial begin
        int         hs;
        int         we_before;
        logic [2:0] op, rd, rs, rt;
        logic [3:0] w;
        logic       c, z;

        vecs = '{
            '{OP_ADD, 3'd3, 3'd1, 3'd2, 4'h5, 4'h3, 4'h8, 1'b0, 1'b0},
            '{OP_SUB, 3'd4, 3'd1, 3'd1, 4'h5, 4'h5, 4'h0, 1'b1, 1'b1},
            '{OP_AND, 3'd5, 3'd6, 3'd7, 4'hC, 4'hA, 4'h8, 1'b1, 1'b0},
            '{OP_OR,  3'd5, 3'd6, 3'd7, 4'hC, 4'hA, 4'hE, 1'b1, 1'b0},
            '{OP_ADD, 3'd0, 3'd6, 3'd7, 4'hF, 4'h1, 4'h0, 1'b1, 1'b1},
            '{OP_SLT, 3'd2, 3'd3, 3'd4, 4'h3, 4'h5, 4'h1, 1'b0, 1'b0},
            '{OP_SLT, 3'd2, 3'd3, 3'd4, 4'h5, 4'h3, 4'h0, 1'b1, 1'b1},
            '{OP_SUB, 3'd1, 3'd1, 3'd2, 4'h3, 4'h5, 4'hE, 1'b0, 1'b0},
            '{3'b011, 3'd7, 3'd6, 3'd5, 4'hC, 4'hA, 4'h0, 1'b1, 1'b1},
            '{3'b100, 3'd7, 3'd6, 3'd5, 4'hC, 4'hA, 4'h4, 1'b1, 1'b0},
            '{3'b101, 3'd7, 3'd6, 3'd5, 4'hC, 4'hA, 4'hD, 1'b1, 1'b0}
        };
        ops = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT};
        for (int i = 0; i < 8; i++) regs[i] = '0;

        // Reset state
        #3;
        chk("rst_ready", instr_ready, 1);
        chk("rst_we", rf_we, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_carry", carry, 0);
        chk("rst_zero", zero, 0);
        chk("rst_alu", {alu_a, alu_b, alu_oper, alu_binvert, alu_cin}, 0);
        chk("rst_rf_addr", {rf_raddr_a, rf_raddr_b, rf_waddr, rf_wdata}, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed table
        for (int i = 0; i < 11; i++) begin
            preload(vecs[i].rs, vecs[i].a);
            preload(vecs[i].rt, vecs[i].b);
            exec_instr($sformatf("vec%0d", i), vecs[i].op, vecs[i].rd, vecs[i].rs, vecs[i].rt,
                       vecs[i].a, vecs[i].b, vecs[i].w, vecs[i].c, vecs[i].z);
        end

        // instr_valid held high for 8 cycles: accepts only on cycles 0 and 4
        hs = 0;
        instr_valid = 1'b1; instr_op = OP_ADD; instr_rd = 3'd5; instr_rs = 3'd1; instr_rt = 3'd2;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (instr_ready) hs++;
            chk($sformatf("hold_ready_c%0d", i), instr_ready, (i % 4) == 0);
            @(posedge clk); #1;
        end
        instr_valid = 1'b0;
        chk("hold_handshakes", hs, 2);

        // Random instructions against the reference register image
        for (int i = 0; i < 8; i++) begin
            ref_regs[i] = 4'($urandom);
            preload(3'(i), ref_regs[i]);
        end
        for (int i = 0; i < 24; i++) begin
            op = ops[$urandom_range(0, 4)];
            rd = 3'($urandom); rs = 3'($urandom); rt = 3'($urandom);
            ref_op(op, ref_regs[rs], ref_regs[rt], w, c, z);
            exec_instr($sformatf("rnd%0d", i), op, rd, rs, rt, ref_regs[rs], ref_regs[rt], w, c, z);
            ref_regs[rd] = w;
        end
        for (int i = 0; i < 8; i++) chk($sformatf("rnd_final_r%0d", i), regs[i], ref_regs[i]);

        // Reset asserted during EXEC aborts without a write
        preload(3'd1, 4'h5);
        preload(3'd2, 4'h3);
        exec_instr("pre_rst", OP_ADD, 3'd3, 3'd1, 3'd2, 4'h5, 4'h3, 4'h8, 1'b0, 1'b0);
        preload(3'd6, 4'h9);
        instr_valid = 1'b1; instr_op = OP_ADD; instr_rd = 3'd6; instr_rs = 3'd6; instr_rt = 3'd6;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        chk("rst_exec_reached", alu_oper, 2'b10);
        we_before = we_pulses;
        rst_n = 1'b0;
        #1;
        chk("midrst_we", rf_we, 0);
        chk("midrst_ready", instr_ready, 1);
        chk("midrst_result", result, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("midrst_hold_we_c%0d", i), rf_we, 0);
            chk($sformatf("midrst_hold_ready_c%0d", i), instr_ready, 1);
            chk($sformatf("midrst_hold_result_c%0d", i), result, 0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk($sformatf("postrst_we_c%0d", i), rf_we, 0);
        end
        chk("midrst_no_write_pulse", we_pulses, we_before);
        chk("midrst_r6_intact", regs[6], 4'h9);
        exec_instr("post_rst", OP_ADD, 3'd6, 3'd6, 3'd6, 4'h9, 4'h9, 4'h2, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
